// File: rtl/axi_lite_reg_bridge.sv
// axi_lite_reg_bridge: single-beat AXI4 slave to one-cycle register strobe, plus a two-flop input synchronizer.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   aw_*/w_*/b_*/ar_*/r_*    AXI4 slave channels (one outstanding transaction, single beat)
//   address_o/en_o/we_o      register strobe, one cycle per transaction
//   data_o/data_i            register write data / read data (sampled in the read strobe cycle)
//   a_i/z_o                  asynchronous input and its synchronized copy
//
// Optional checks: define AXI_LITE_BRIDGE_ASSERT_EN (simulation only).
module axi_lite_reg_bridge #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic                        aw_valid,
    output logic                        aw_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                        w_last,
    input  logic                        w_valid,
    output logic                        w_ready,
    output logic [AXI_ID_WIDTH-1:0]     b_id,
    output logic [1:0]                  b_resp,
    output logic                        b_valid,
    input  logic                        b_ready,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic                        ar_valid,
    output logic                        ar_ready,
    output logic [AXI_ID_WIDTH-1:0]     r_id,
    output logic [AXI_DATA_WIDTH-1:0]   r_data,
    output logic [1:0]                  r_resp,
    output logic                        r_last,
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   address_o,
    output logic                        en_o,
    output logic                        we_o,
    output logic [AXI_DATA_WIDTH-1:0]   data_o,
    input  logic [AXI_DATA_WIDTH-1:0]   data_i,
    input  logic                        a_i,
    output logic                        z_o
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, WRITE_B} state_e;

    state_e                      state_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_ID_WIDTH-1:0]     id_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                  sync_q;
    logic                        rd_hs, wr_hs;
    logic                        unused;

    // Strobe and burst qualifiers are ignored: every write is a full word.
    assign unused = ^{w_strb, w_last};

    assign rd_hs     = (state_q == IDLE) && ar_valid;
    assign wr_hs     = (state_q == WRITE) && w_valid;
    assign ar_ready  = state_q == IDLE;
    // Reads win a same-cycle tie, so AW is only accepted when no AR competes.
    assign aw_ready  = (state_q == IDLE) && !ar_valid;
    assign w_ready   = state_q == WRITE;
    assign b_valid   = state_q == WRITE_B;
    assign r_valid   = state_q == READ;
    assign b_id      = id_q;
    assign r_id      = id_q;
    assign r_data    = rdata_q;
    assign b_resp    = 2'b00;
    assign r_resp    = 2'b00;
    assign r_last    = r_valid;
    assign en_o      = rd_hs || wr_hs;
    assign we_o      = wr_hs;
    assign address_o = rd_hs ? ar_addr : wr_hs ? addr_q : '0;
    assign data_o    = wr_hs ? w_data : '0;
    assign z_o       = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_valid) begin
                        state_q <= READ;
                        id_q    <= ar_id;
                        rdata_q <= data_i;
                    end else if (aw_valid) begin
                        state_q <= WRITE;
                        id_q    <= aw_id;
                        addr_q  <= aw_addr;
                    end
                end
                READ:    if (r_ready) state_q <= IDLE;
                WRITE:   if (w_valid) state_q <= WRITE_B;
                WRITE_B: if (b_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[0], a_i};
    end

`ifdef AXI_LITE_BRIDGE_ASSERT_EN
    initial if (AXI_DATA_WIDTH != 64) $fatal(1, "axi_lite_reg_bridge: AXI_DATA_WIDTH must be 64");
    a_en_single: assert property (@(posedge clk_i) disable iff (!rst_ni) en_o |=> !en_o);
    a_r_hold:    assert property (@(posedge clk_i) disable iff (!rst_ni) r_valid && !r_ready |=> r_valid);
    a_b_hold:    assert property (@(posedge clk_i) disable iff (!rst_ni) b_valid && !b_ready |=> b_valid);
`else
`endif
endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// tb_axi_lite_reg_bridge: vector table, corner sequences and random traffic against a transaction-level model.
module tb_axi_lite_reg_bridge;
    logic        clk_i = 0, rst_ni = 0;
    logic [9:0]  aw_id = 0, ar_id = 0, b_id, r_id;
    logic [63:0] aw_addr = 0, ar_addr = 0, w_data = 0, r_data, address_o, data_o, data_i;
    logic [7:0]  w_strb = 0;
    logic        aw_valid = 0, aw_ready, w_last = 0, w_valid = 0, w_ready, b_valid, b_ready = 0;
    logic        ar_valid = 0, ar_ready, r_last, r_valid, r_ready = 0, en_o, we_o, a_i = 0, z_o;
    logic [1:0]  b_resp, r_resp;

    always #5 clk_i = ~clk_i;

    axi_lite_reg_bridge dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
        .address_o(address_o), .en_o(en_o), .we_o(we_o), .data_o(data_o), .data_i(data_i),
        .a_i(a_i), .z_o(z_o)
    );

    // Peripheral emulation: either a directly driven read value or a small register file.
    logic        rf_mode = 0;
    logic [63:0] data_drv = 0;
    logic [63:0] rf [8];
    logic [63:0] ref_mem [8];
    assign data_i = rf_mode ? rf[address_o[5:3]] : data_drv;

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (en_o && we_o) begin
            rf[address_o[5:3]] <= data_o;
        end
    end

    typedef struct packed {logic we; logic [63:0] a; logic [63:0] d;} strobe_t;
    strobe_t log_q[$], exp_q[$];
    int   double_en = 0;
    logic prev_en = 0;

    always @(negedge clk_i) begin
        if (rst_ni && en_o) log_q.push_back({we_o, address_o, data_o});
        if (rst_ni && en_o && prev_en) double_en++;
        prev_en = rst_ni && en_o;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [9:0] id, input logic [63:0] drv,
                           input logic [63:0] exp_addr, input logic [63:0] exp_d, input logic [9:0] exp_id,
                           input int stall);
        ar_valid = 1; ar_addr = addr; ar_id = id; data_drv = drv;
        @(negedge clk_i);
        chk("rd_ar_ready", ar_ready, 1);
        chk("rd_aw_ready_tie", aw_ready, 0);
        chk("rd_en", en_o, 1);
        chk("rd_we", we_o, 0);
        chk("rd_addr", address_o, exp_addr);
        tick();
        ar_valid = 0; data_drv = {$urandom(), $urandom()};
        exp_q.push_back({1'b0, exp_addr, 64'h0});
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) r_ready = 1;
            @(negedge clk_i);
            chk("rd_r_valid", r_valid, 1);
            chk("rd_r_data", r_data, exp_d);
            chk("rd_r_id", r_id, exp_id);
            chk("rd_ar_ready_busy", ar_ready, 0);
            chk("rd_aw_ready_busy", aw_ready, 0);
            chk("rd_no_en", en_o, 0);
            if (i == stall) begin
                chk("rd_r_resp", r_resp, 0);
                chk("rd_r_last", r_last, 1);
            end
            tick();
        end
        r_ready = 0;
        chk("rd_r_valid_drop", r_valid, 0);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [9:0] id, input logic [63:0] data,
                            input logic [63:0] exp_addr, input logic [63:0] exp_d, input logic [9:0] exp_id,
                            input int wdly, input int bdly);
        aw_valid = 1; aw_addr = addr; aw_id = id;
        @(negedge clk_i);
        chk("wr_aw_ready", aw_ready, 1);
        chk("wr_aw_no_en", en_o, 0);
        chk("wr_w_ready_idle", w_ready, 0);
        tick();
        aw_valid = 0;
        for (int i = 0; i <= wdly; i++) begin
            if (i == wdly) begin
                w_valid = 1; w_data = data; w_strb = 8'($urandom()); w_last = 1'($urandom());
            end
            @(negedge clk_i);
            chk("wr_w_ready", w_ready, 1);
            chk("wr_ar_ready_busy", ar_ready, 0);
            chk("wr_aw_ready_busy", aw_ready, 0);
            chk("wr_en", en_o, 64'(i == wdly));
            if (i == wdly) begin
                chk("wr_we", we_o, 1);
                chk("wr_addr", address_o, exp_addr);
                chk("wr_data", data_o, exp_d);
            end
            tick();
        end
        w_valid = 0;
        exp_q.push_back({1'b1, exp_addr, exp_d});
        ref_mem[exp_addr[5:3]] = exp_d;
        for (int i = 0; i <= bdly; i++) begin
            if (i == bdly) b_ready = 1;
            @(negedge clk_i);
            chk("wr_b_valid", b_valid, 1);
            chk("wr_b_id", b_id, exp_id);
            chk("wr_b_resp", b_resp, 0);
            chk("wr_b_w_ready", w_ready, 0);
            chk("wr_b_no_en", en_o, 0);
            tick();
        end
        b_ready = 0;
        chk("wr_b_valid_drop", b_valid, 0);
    endtask

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [9:0]  id;
        logic [63:0] data;
        int          d1, d2;
        logic [63:0] exp_addr;
        logic [63:0] exp_data;
        logic [9:0]  exp_id;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{0, 64'h400, 10'd5, 64'hDEAD_BEEF, 0, 0, 64'h400, 64'hDEAD_BEEF, 10'd5};
        vt[1] = '{1, 64'hC00, 10'd3, 64'h1234, 2, 0, 64'hC00, 64'h1234, 10'd3};
        vt[2] = '{0, 64'h808, 10'h2A, 64'h0123_4567_89AB_CDEF, 10, 0, 64'h808, 64'h0123_4567_89AB_CDEF, 10'h2A};
        vt[3] = '{1, 64'hFFFF_FFFF_FFFF_FFF8, 10'h3FF, '1, 0, 4, 64'hFFFF_FFFF_FFFF_FFF8, '1, 10'h3FF};
        vt[4] = '{0, 64'h0, 10'h0, 64'h0, 1, 0, 64'h0, 64'h0, 10'h0};
        vt[5] = '{1, 64'h10, 10'h155, 64'hA5A5_5A5A_0F0F_F0F0, 1, 1, 64'h10, 64'hA5A5_5A5A_0F0F_F0F0, 10'h155};
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;

        repeat (2) @(negedge clk_i);
        chk("rst_aw_ready", aw_ready, 1);
        chk("rst_ar_ready", ar_ready, 1);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_en", en_o, 0);
        chk("rst_z", z_o, 0);
        tick();
        rst_ni = 1;
        tick();

        for (int i = 0; i < 6; i++) begin
            if (vt[i].wr) do_write(vt[i].addr, vt[i].id, vt[i].data, vt[i].exp_addr, vt[i].exp_data, vt[i].exp_id, vt[i].d1, vt[i].d2);
            else          do_read(vt[i].addr, vt[i].id, vt[i].data, vt[i].exp_addr, vt[i].exp_data, vt[i].exp_id, vt[i].d1);
        end

        // AR and AW together: read first, then the still-pending write.
        aw_valid = 1; aw_addr = 64'h2000; aw_id = 10'd9;
        do_read(64'h1000, 10'd8, 64'h55, 64'h1000, 64'h55, 10'd8, 2);
        do_write(64'h2000, 10'd9, 64'h77, 64'h2000, 64'h77, 10'd9, 0, 0);

        // W before AW is held off in IDLE.
        w_valid = 1; w_data = 64'h5555;
        @(negedge clk_i);
        chk("early_w_ready", w_ready, 0);
        chk("early_w_no_en", en_o, 0);
        tick();
        w_valid = 0;
        do_write(64'h3008, 10'd1, 64'h6666, 64'h3008, 64'h6666, 10'd1, 0, 0);

        // Synchronizer latency.
        a_i = 1;
        @(negedge clk_i);
        chk("sync_edge0", z_o, 0);
        tick();
        @(negedge clk_i);
        chk("sync_edge1", z_o, 0);
        tick();
        @(negedge clk_i);
        chk("sync_edge2", z_o, 1);
        tick();

        // Reset in the middle of a write.
        aw_valid = 1; aw_addr = 64'hABC0; aw_id = 10'd7;
        tick();
        aw_valid = 0;
        @(negedge clk_i);
        chk("mid_w_ready", w_ready, 1);
        chk("mid_z_pre", z_o, 1);
        #1 rst_ni = 0;
        #1;
        chk("mid_rst_w_ready", w_ready, 0);
        chk("mid_rst_b_valid", b_valid, 0);
        chk("mid_rst_r_valid", r_valid, 0);
        chk("mid_rst_z", z_o, 0);
        chk("mid_rst_aw_ready", aw_ready, 1);
        chk("mid_rst_ar_ready", ar_ready, 1);
        a_i = 0;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        tick();
        rst_ni = 1;
        @(negedge clk_i);
        chk("post_rst_aw_ready", aw_ready, 1);
        chk("post_rst_ar_ready", ar_ready, 1);
        tick();

        // Random traffic against the register-file model.
        rf_mode = 1;
        for (int n = 0; n < 40; n++) begin
            logic [63:0] a, d;
            logic [9:0]  id;
            a  = {$urandom(), $urandom()};
            d  = {$urandom(), $urandom()};
            id = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1)
                do_write(a, id, d, a, d, id, $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, id, 64'h0, a, ref_mem[a[5:3]], id, $urandom_range(0, 3));
        end

        repeat (2) tick();
        chk("strobe_count", 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            chk("strobe_we", log_q[i].we, exp_q[i].we);
            chk("strobe_addr", log_q[i].a, exp_q[i].a);
            chk("strobe_data", log_q[i].d, exp_q[i].d);
        end
        chk("double_en", 64'(double_en), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_reg_bridge.md
# axi_lite_reg_bridge

AXI4 slave front-end that converts single-beat read/write transactions into a one-cycle register-file strobe (address, enable, write-enable, write data, read data). It also provides a two-flop synchronizer for one asynchronous input (for example an RTC line). It sits between the SoC AXI interconnect and small peripheral register banks such as the machine timer.

## Interface

- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 64, data width.
- AXI_ID_WIDTH, 10, transaction ID width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- aw_id / aw_addr / aw_valid  in  ID/ADDR/1  write address channel; aw_ready  out  1.
- w_data / w_strb / w_last / w_valid  in  DATA/DATA/8/1/1  write data channel; w_ready  out  1.
- b_id / b_resp / b_valid  out  ID/2/1  write response channel; b_ready  in  1.
- ar_id / ar_addr / ar_valid  in  ID/ADDR/1  read address channel; ar_ready  out  1.
- r_id / r_data / r_resp / r_last / r_valid  out  ID/DATA/2/1/1  read data channel; r_ready  in  1.
- address_o  out  ADDR  register address, valid while en_o=1.
- en_o  out  1  register access strobe, one cycle per transaction.
- we_o  out  1  1 = write, 0 = read; qualified by en_o.
- data_o  out  DATA  write data; equals w_data while en_o&we_o.
- data_i  in  DATA  read data from the register file, sampled combinationally in the en_o&!we_o cycle.
- a_i  in  1  asynchronous input.
- z_o  out  1  a_i synchronized to clk_i.

## Operation

- The bridge allows one outstanding transaction.
- len, size and burst are ignored; every transaction is a single beat. w_last and w_strb are ignored, so a write is always a full-word write.
- The FSM has four states: IDLE, READ, WRITE, WRITE_B.
- **IDLE**
  - aw_ready=1 and ar_ready=1; all other handshake outputs are 0.
  - ar_valid has priority over aw_valid in the same cycle.
  - On ar_valid: en_o=1, we_o=0, address_o=ar_addr. Register data_i into r_data and ar_id into r_id, then go to READ.
  - Otherwise, on aw_valid: register aw_addr and aw_id, then go to WRITE.
- **READ**
  - r_valid=1, r_resp=OKAY (2'b00), r_last=1.
  - r_data and r_id stay stable until r_ready; on r_ready go to IDLE.
- **WRITE**
  - w_ready=1; aw_ready and ar_ready are 0.
  - On w_valid: en_o=1, we_o=1, address_o=captured address, data_o=w_data. Go to WRITE_B.
- **WRITE_B**
  - b_valid=1, b_resp=OKAY, b_id=captured ID.
  - On b_ready go to IDLE.
- en_o is never asserted outside the two strobe cycles above. When en_o=0, address_o, we_o and data_o are don't-care; drive them 0.
- Synchronizer: two cascaded flops clocked by clk_i; z_o is the second flop.

## Timing

- Reset state: FSM=IDLE, so aw_ready=ar_ready=1 (combinational from state). b_valid=r_valid=w_ready=en_o=0, captured address/ID/data=0, synchronizer flops=0, z_o=0.
- Read: AR handshake at cycle N (en_o high at N); r_valid rises at N+1. Back-to-back reads issue at most one every 2 cycles.
- Write: AW handshake at N; w_ready high from N+1; en_o high in the W handshake cycle M; b_valid high at M+1.
- A W beat presented before or together with AW is held off until WRITE (w_ready=0 in IDLE).
- A stalled r_ready or b_ready holds the state indefinitely, with outputs stable.
- Synchronizer latency: a change on a_i appears on z_o after 2 rising edges.
- Asserting reset mid-transaction aborts it immediately: state returns to IDLE and pending responses are dropped.

## Configuration

- AXI_LITE_BRIDGE_ASSERT_EN:
  - When defined (simulation only), the block checks AXI_DATA_WIDTH==64 at elaboration and fatals otherwise.
  - It also flags an error if en_o is high for two consecutive cycles, or if r_valid or b_valid drops before its ready.
  - When undefined, there are no checks and identical RTL behaviour.

## Test plan

- Read 0x400 with ar_id=5 and data_i=0xDEAD_BEEF → en_o=1, we_o=0, address_o=0x400 at cycle N; r_valid at N+1 with r_data=0xDEADBEEF, r_id=5, r_resp=0, r_last=1.
- Write 0xC00 with aw_id=3, then W 0x1234 two cycles later → one en_o&we_o pulse with address_o=0xC00, data_o=0x1234; b_valid next cycle with b_id=3, b_resp=0.
- ar_valid and aw_valid together in IDLE → read serviced first, aw_ready=0 until return to IDLE, then the write completes.
- Hold r_ready=0 for 10 cycles → r_valid and r_data stable, ar_ready=aw_ready=0, no en_o pulses.
- Step a_i 0→1 → z_o rises exactly 2 clk_i edges later; assert rst_ni low mid-write → all valids 0, z_o=0, next cycle ready=1.
